// File: rtl/spi_slave_fifo_periph.sv
// SPI slave peripheral with TX/RX FIFOs, CPOL/CPHA modes, runtime word
// length, sticky error flags and a maskable interrupt line.
// Optional macro SPI_LSB_FIRST_EN adds CTRL[13] LSBF (LSB-first transfers).
//
// Engine states:
//   state | meaning
//   IDLE  | not selected or disabled, MISO held low
//   SHIFT | selected, shifting words between the pins and the FIFOs

module spi_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok, push_ok;

  // a pop frees a slot, so a push into a full FIFO is accepted alongside it
  assign pop_ok  = pop && (level != '0);
  assign push_ok = push && ((level != (AW+1)'(DEPTH)) || pop_ok);
  assign dout    = mem[rd_ptr];

  // pointers and fill level; flush overrides any push or pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end
endmodule

module spi_slave_fifo_periph #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int RST_LEN = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  i_dbus_adr,
  input  logic        i_dbus_cyc,
  input  logic        i_dbus_we,
  input  logic [31:0] i_dbus_dat,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_int,
  input  logic        i_SCLK,
  input  logic        i_CSn,
  input  logic        i_MOSI,
  output logic        o_MISO,
  output logic        o_MISO_oe
);
  localparam int         LW      = $clog2(DEPTH) + 1;
  localparam logic [4:0] LEN_MAX = 5'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;

  logic              sclk_m, sclk_s, sclk_d, csn_m, csn_s, csn_d, mosi_m, mosi_s;
  logic [4:0]        len_q, len_eff;
  logic              cpol_q, cpha_q, en_q, lsbf;
  logic [3:0]        ie_q;
  logic [2:0]        st_q, st_set, st_clr;
  logic              bus_wr, bus_rd, tx_push, rx_pop, ctrl_wr, flush;
  logic [DATA_W-1:0] tx_dout, rx_dout, tx_sr, rx_sr, rx_next, word_mask;
  logic [LW-1:0]     tx_level, rx_level;
  logic              tx_empty, tx_full, rx_empty, rx_full, tx_pop_eng, rx_drop;
  logic              sclk_rise, sclk_fall, lead, trail, sample_edge, shift_edge, csn_fall;
  logic              load, sample, shift, eow;
  logic [5:0]        bitcnt;
  logic              unused_dat;

  assign unused_dat = ^i_dbus_dat[31:13];

  assign bus_wr  = i_dbus_cyc & i_dbus_we & o_dbus_ack;
  assign bus_rd  = i_dbus_cyc & ~i_dbus_we & o_dbus_ack;
  assign tx_push = bus_wr & (i_dbus_adr == 2'd0);
  assign rx_pop  = bus_rd & (i_dbus_adr == 2'd0);
  assign ctrl_wr = bus_wr & (i_dbus_adr == 2'd1);
  assign flush   = ctrl_wr & i_dbus_dat[8];
  assign st_clr  = (bus_wr && i_dbus_adr == 2'd2) ? i_dbus_dat[7:5] : 3'b000;

  // single-cycle acknowledge one clock after the request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) o_dbus_ack <= 1'b0;
    else       o_dbus_ack <= i_dbus_cyc & ~o_dbus_ack;
  end

  // CTRL register fields
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q  <= 5'(RST_LEN);
      cpha_q <= 1'b0;
      cpol_q <= 1'b0;
      en_q   <= 1'b1;
      ie_q   <= 4'b0;
    end else if (ctrl_wr) begin
      len_q  <= i_dbus_dat[4:0];
      cpha_q <= i_dbus_dat[5];
      cpol_q <= i_dbus_dat[6];
      en_q   <= i_dbus_dat[7];
      ie_q   <= i_dbus_dat[12:9];
    end
  end

`ifdef SPI_LSB_FIRST_EN
  // bit-order select
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        lsbf <= 1'b0;
    else if (ctrl_wr) lsbf <= i_dbus_dat[13];
  end
`else
  assign lsbf = 1'b0;
`endif

  // sticky flags {rx word, tx underflow, rx overflow}; a same-cycle set beats the clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st_q <= 3'b0;
    else       st_q <= (st_q & ~st_clr) | st_set;
  end

  // register read mux
  always_comb begin
    o_dbus_rdt = '0;
    case (i_dbus_adr)
      2'd0: if (!rx_empty) o_dbus_rdt = 32'(rx_dout);
      2'd1: o_dbus_rdt = {18'b0, lsbf, ie_q, 1'b0, en_q, cpol_q, cpha_q, len_q};
      2'd2: o_dbus_rdt = {8'b0, 8'(tx_level), 8'(rx_level), st_q,
                          rx_full, rx_empty, tx_full, tx_empty, ~csn_s};
      default: o_dbus_rdt = '0;
    endcase
  end

  assign o_int = (tx_empty & ie_q[0]) | (rx_full & ie_q[1]) | (st_q[2] & ie_q[2])
               | ((st_q[0] | st_q[1]) & ie_q[3]);

  spi_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rstn(rstn), .flush(flush), .push(tx_push), .pop(tx_pop_eng),
    .din(i_dbus_dat[DATA_W-1:0]), .dout(tx_dout), .level(tx_level)
  );

  spi_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rstn(rstn), .flush(flush), .push(eow), .pop(rx_pop),
    .din(rx_next & word_mask), .dout(rx_dout), .level(rx_level)
  );

  assign tx_empty = (tx_level == '0);
  assign tx_full  = (tx_level == LW'(DEPTH));
  assign rx_empty = (rx_level == '0);
  assign rx_full  = (rx_level == LW'(DEPTH));

  // 2-FF pin synchronisers plus one stage of history for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {sclk_m, sclk_s, sclk_d} <= 3'b000;
      {csn_m, csn_s, csn_d}    <= 3'b111;
      {mosi_m, mosi_s}         <= 2'b00;
    end else begin
      {sclk_m, sclk_s, sclk_d} <= {i_SCLK, sclk_m, sclk_s};
      {csn_m, csn_s, csn_d}    <= {i_CSn, csn_m, csn_s};
      {mosi_m, mosi_s}         <= {i_MOSI, mosi_m};
    end
  end

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead        = cpol_q ? sclk_fall : sclk_rise;
  assign trail       = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail : lead;
  assign shift_edge  = cpha_q ? lead : trail;
  assign csn_fall    = ~csn_s & csn_d;

  assign len_eff   = (len_q > LEN_MAX) ? LEN_MAX : len_q;
  assign word_mask = {DATA_W{1'b1}} >> (LEN_MAX - len_eff);
  assign rx_next   = lsbf ? ((rx_sr >> 1) | (DATA_W'(mosi_s) << len_eff))
                          : {rx_sr[DATA_W-2:0], mosi_s};

  assign tx_pop_eng = load & ~tx_empty;
  assign rx_drop    = eow & rx_full & ~rx_pop;
  assign st_set     = {eow & ~rx_drop, load & tx_empty, rx_drop};

  // engine state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // engine next state; the first shift edge after a load re-presents the MSB instead of shifting
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    sample  = 1'b0;
    shift   = 1'b0;
    eow     = 1'b0;
    case (state_q)
      IDLE: if (en_q && csn_fall) begin
        state_d = SHIFT;
        load    = 1'b1;
      end
      SHIFT: if (!en_q || csn_s) begin
        state_d = IDLE;
      end else if (sample_edge) begin
        sample = 1'b1;
        if (bitcnt == {1'b0, len_eff}) begin
          eow  = 1'b1;
          load = 1'b1;
        end
      end else if (shift_edge && bitcnt != '0) begin
        shift = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // shift registers and bit counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_sr  <= '0;
      rx_sr  <= '0;
      bitcnt <= '0;
    end else if (load) begin
      tx_sr  <= tx_empty ? '0 : tx_dout;
      rx_sr  <= '0;
      bitcnt <= '0;
    end else if (state_d == IDLE) begin
      bitcnt <= '0;
    end else if (sample) begin
      rx_sr  <= rx_next;
      bitcnt <= bitcnt + 6'd1;
    end else if (shift) begin
      tx_sr  <= lsbf ? (tx_sr >> 1) : (tx_sr << 1);
    end
  end

  assign o_MISO    = (state_q == SHIFT) & en_q & (lsbf ? tx_sr[0] : tx_sr[len_eff]);
  assign o_MISO_oe = (state_q == SHIFT);
endmodule

// File: tb/tb_spi_slave_fifo_periph.sv
// Randomised bench for spi_slave_fifo_periph against a queue-based model.
module tb_spi_slave_fifo_periph;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int H      = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  i_dbus_adr;
  logic        i_dbus_cyc, i_dbus_we;
  logic [31:0] i_dbus_dat, o_dbus_rdt;
  logic        o_dbus_ack, o_int;
  logic        i_SCLK, i_CSn, i_MOSI, o_MISO, o_MISO_oe;

  always #5 clk = ~clk;

  spi_slave_fifo_periph #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RST_LEN(7)) dut (
    .clk(clk), .rstn(rstn),
    .i_dbus_adr(i_dbus_adr), .i_dbus_cyc(i_dbus_cyc), .i_dbus_we(i_dbus_we),
    .i_dbus_dat(i_dbus_dat), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_int(o_int), .i_SCLK(i_SCLK), .i_CSn(i_CSn), .i_MOSI(i_MOSI),
    .o_MISO(o_MISO), .o_MISO_oe(o_MISO_oe)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit          m_st5, m_st6, m_st7;
  logic [3:0]  m_ie;
  int          cur_nb;
  bit          cur_cpol, cur_cpha, cur_lsbf;
  logic        first_miso;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int nb);
    logic [31:0] one = 32'h1;
    return (nb >= 32) ? 32'hFFFF_FFFF : (one << nb) - 32'h1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s = '0;
    s[1]     = (tx_q.size() == 0);
    s[2]     = (tx_q.size() == DEPTH);
    s[3]     = (rx_q.size() == 0);
    s[4]     = (rx_q.size() == DEPTH);
    s[5]     = m_st5;
    s[6]     = m_st6;
    s[7]     = m_st7;
    s[15:8]  = 8'(rx_q.size());
    s[23:16] = 8'(tx_q.size());
    return s;
  endfunction

  function automatic logic exp_int();
    return ((tx_q.size() == 0) & m_ie[0]) | ((rx_q.size() == DEPTH) & m_ie[1])
         | (m_st7 & m_ie[2]) | ((m_st5 | m_st6) & m_ie[3]);
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [1:0] adr, input logic we, input logic [31:0] dat,
                     output logic [31:0] rdt);
    i_dbus_adr = adr;
    i_dbus_we  = we;
    i_dbus_dat = dat;
    i_dbus_cyc = 1'b1;
    for (int n = 0; n < 4 && !o_dbus_ack; n++) wait_clks(1);
    check("ack", {31'b0, o_dbus_ack}, 32'h1);
    rdt = o_dbus_rdt;
    wait_clks(1);
    i_dbus_cyc = 1'b0;
    i_dbus_we  = 1'b0;
    check("ack_pulse", {31'b0, o_dbus_ack}, 32'h0);
  endtask

  task automatic model_load(output logic [31:0] w);
    if (tx_q.size() > 0) w = tx_q.pop_front();
    else begin
      w = '0;
      m_st6 = 1'b1;
    end
  endtask

  task automatic model_push(input logic [31:0] w);
    if (rx_q.size() < DEPTH) begin
      rx_q.push_back(w);
      m_st7 = 1'b1;
    end else m_st5 = 1'b1;
  endtask

  task automatic set_ctrl(input int len, input bit cpol, input bit cpha, input logic [3:0] ie,
                          input bit lsbf, input bit flush);
    logic [31:0] v, r, e;
    v = 32'(len) | (32'(cpha) << 5) | (32'(cpol) << 6) | (32'h1 << 7) | (32'(flush) << 8)
      | (32'(ie) << 9) | (32'(lsbf) << 13);
    bus(2'd1, 1'b1, v, r);
    if (flush) begin
      tx_q.delete();
      rx_q.delete();
    end
    m_ie     = ie;
    cur_nb   = len + 1;
    cur_cpol = cpol;
    cur_cpha = cpha;
    e = v & ~(32'h1 << 8);
`ifdef SPI_LSB_FIRST_EN
    cur_lsbf = lsbf;
`else
    cur_lsbf = 1'b0;
    e = e & ~(32'h1 << 13);
`endif
    i_SCLK = cpol;
    wait_clks(4);
    bus(2'd1, 1'b0, 32'h0, r);
    check("ctrl", r, e);
  endtask

  task automatic tx_write(input logic [31:0] w);
    logic [31:0] r;
    bus(2'd0, 1'b1, w, r);
    if (tx_q.size() < DEPTH) tx_q.push_back(w);
  endtask

  task automatic rx_read();
    logic [31:0] r, e;
    bus(2'd0, 1'b0, 32'h0, r);
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 32'h0;
    check("rx_data", r, e);
  endtask

  task automatic chk_status();
    logic [31:0] r;
    bus(2'd2, 1'b0, 32'h0, r);
    check("status", r, exp_status());
    check("int", {31'b0, o_int}, {31'b0, exp_int()});
  endtask

  task automatic clr_flags(input logic [31:0] v);
    logic [31:0] r;
    bus(2'd2, 1'b1, v, r);
    if (v[5]) m_st5 = 1'b0;
    if (v[6]) m_st6 = 1'b0;
    if (v[7]) m_st7 = 1'b0;
  endtask

  // master side: cut > 0 raises CSn after that many bits of the first word
  task automatic spi_frame(input int nw, input int cut, input logic [31:0] fixed, input bit use_fixed);
    logic [31:0] w, exp_tx, got, rmask;
    int idx, nbits;
    i_SCLK = cur_cpol;
    i_CSn  = 1'b1;
    wait_clks(4);
    i_CSn = 1'b0;
    model_load(exp_tx);
    wait_clks(2 * H);
    for (int k = 0; k < nw; k++) begin
      w = (use_fixed ? fixed : $urandom) & wmask(cur_nb);
      got   = '0;
      rmask = '0;
      nbits = (cut > 0) ? cut : cur_nb;
      for (int b = 0; b < nbits; b++) begin
        idx = cur_lsbf ? b : cur_nb - 1 - b;
        if (!cur_cpha) begin
          i_MOSI = w[idx];
          wait_clks(H);
          got[idx] = o_MISO;
          i_SCLK = ~i_SCLK;
          wait_clks(H);
          i_SCLK = ~i_SCLK;
        end else begin
          wait_clks(H);
          i_SCLK = ~i_SCLK;
          i_MOSI = w[idx];
          wait_clks(H);
          got[idx] = o_MISO;
          i_SCLK = ~i_SCLK;
        end
        rmask[idx] = 1'b1;
        if (k == 0 && b == 0) first_miso = got[idx];
      end
      if (cut > 0) begin
        check("miso_partial", got, exp_tx & rmask);
        break;
      end
      check("miso_word", got, exp_tx & wmask(cur_nb));
      model_push(w);
      model_load(exp_tx);
    end
    wait_clks(H);
    i_CSn = 1'b1;
    wait_clks(6);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int len;
    rstn = 1'b0;
    i_dbus_adr = '0; i_dbus_cyc = 1'b0; i_dbus_we = 1'b0; i_dbus_dat = '0;
    i_SCLK = 1'b0; i_CSn = 1'b1; i_MOSI = 1'b0;
    m_st5 = 0; m_st6 = 0; m_st7 = 0; m_ie = '0;
    cur_nb = 8; cur_cpol = 0; cur_cpha = 0; cur_lsbf = 0;
    wait_clks(3);
    rstn = 1'b1;
    wait_clks(2);

    check("rst_outs", {28'b0, o_dbus_ack, o_int, o_MISO, o_MISO_oe}, 32'h0);
    bus(2'd1, 1'b0, 32'h0, r);
    check("rst_ctrl", r, 32'h087);
    chk_status();

    // basic mode 0, 8-bit exchange
    set_ctrl(7, 0, 0, 4'b0, 0, 0);
    tx_write(32'hA5);
    spi_frame(1, 0, 32'h3C, 1);
    rx_read();
    chk_status();
    clr_flags(32'hE0);

    // all modes, several lengths, back-to-back words under one CSn
    for (int m = 0; m < 4; m++) begin
      for (int li = 0; li < 3; li++) begin
        len = (li == 0) ? 15 : (li == 1) ? 31 : int'($urandom_range(0, 31));
        set_ctrl(len, m[1], m[0], 4'b0, 0, 0);
        for (int k = 0; k < 3; k++) tx_write($urandom);
        spi_frame(3, 0, 32'h0, 0);
        for (int k = 0; k < 3; k++) rx_read();
        chk_status();
        clr_flags(32'hE0);
      end
    end

    // RX overflow with error interrupt enabled
    set_ctrl(7, 0, 0, 4'b1000, 0, 0);
    spi_frame(DEPTH + 1, 0, 32'h0, 0);
    chk_status();
    clr_flags(32'h20);
    chk_status();
    for (int k = 0; k < DEPTH + 1; k++) rx_read();
    clr_flags(32'hE0);
    chk_status();

    // underflow plus aborted partial word, then a clean word
    set_ctrl(7, 1, 1, 4'b0, 0, 0);
    spi_frame(1, 3, 32'h0, 0);
    chk_status();
    tx_write($urandom);
    spi_frame(1, 0, 32'h0, 0);
    rx_read();
    chk_status();
    clr_flags(32'hE0);

    // flush empties both FIFOs
    set_ctrl(7, 0, 0, 4'b0011, 0, 0);
    tx_write($urandom);
    spi_frame(1, 0, 32'h0, 0);
    tx_write($urandom);
    tx_write($urandom);
    chk_status();
    set_ctrl(7, 0, 0, 4'b0011, 0, 1);
    chk_status();
    clr_flags(32'hE0);

`ifdef SPI_LSB_FIRST_EN
    set_ctrl(7, 0, 0, 4'b0, 1, 0);
    tx_write(32'h01);
    spi_frame(1, 0, 32'h80, 1);
    check("lsbf_first_bit", {31'b0, first_miso}, 32'h1);
    rx_read();
    for (int m = 0; m < 4; m++) begin
      set_ctrl(int'($urandom_range(0, 31)), m[1], m[0], 4'b0, 1, 0);
      for (int k = 0; k < 2; k++) tx_write($urandom);
      spi_frame(2, 0, 32'h0, 0);
      for (int k = 0; k < 2; k++) rx_read();
    end
    chk_status();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_slave_fifo_periph.md
Name: spi_slave_fifo_periph

Overview:
- Parametrised SPI slave peripheral for the RISC-V SoC data bus. Supersedes the fixed 8-bit slave.
- Word width up to DATA_W bits, runtime length 1..DATA_W, CPOL/CPHA modes, FIFO depth set by parameter.
- Bus-visible TX/RX FIFO levels, sticky overflow/underflow error flags, per-source maskable interrupt line to the core.
- SPI pins are oversampled in the clk domain.

Parameters:
- DATA_W, 32, maximum SPI word width in bits (8..32).
- DEPTH, 8, entries per TX/RX FIFO (power of two, 2..128).
- RST_LEN, 7, reset value of LEN field (word length minus one).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- i_dbus_adr  in  2  register select: 0 DATA, 1 CTRL, 2 STATUS
- i_dbus_cyc  in  1  bus cycle request
- i_dbus_we  in  1  write enable
- i_dbus_dat  in  32  write data
- o_dbus_rdt  out  32  read data
- o_dbus_ack  out  1  single-cycle acknowledge
- o_int  out  1  level interrupt
- i_SCLK  in  1  SPI clock from master
- i_CSn  in  1  chip select, active low
- i_MOSI  in  1  master-out data
- o_MISO  out  1  slave-out data
- o_MISO_oe  out  1  MISO output enable, high while selected

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rstn).
- Reset values:
  - FIFOs empty, engine IDLE.
  - o_dbus_ack=0, o_int=0, o_MISO=0, o_MISO_oe=0.
  - CTRL = LEN RST_LEN, mode 00, EN=1, all int enables 0.
- Bus handshake:
  - o_dbus_ack <= cyc & !ack, so ack is a one-clk pulse one cycle after cyc.
  - A write or FIFO pop takes effect only in the ack cycle.
  - o_dbus_rdt is combinational from adr.
- DATA register:
  - Write pushes i_dbus_dat[DATA_W-1:0] into the TX FIFO. A push while TX is full is dropped.
  - Read returns the RX head, zero-extended, and pops in the ack cycle. Reading while RX is empty returns 0 with no pop.
- CTRL register (R/W):
  - [4:0] LEN; bits per word = LEN+1, clamped to DATA_W.
  - [6] CPOL, [5] CPHA, [7] EN.
  - [8] FLUSH: write 1 empties both FIFOs in the same cycle; reads back 0.
  - [12:9] IE: TXEMPTY, RXFULL, RXWORD, ERR.
- STATUS register:
  - [0] busy (CSn low, synchronised).
  - [1] TX empty, [2] TX full, [3] RX empty, [4] RX full.
  - [5] RX overflow, [6] TX underflow, [7] RX word pending. These three are sticky; writing 1 clears, writing 0 has no effect.
  - [15:8] RX level, [23:16] TX level. Both are 0..DEPTH, so DEPTH is representable.
- o_int = (TXempty&IE0) | (RXfull&IE1) | (st7&IE2) | ((st5|st6)&IE3).
- Pin synchronisers: SCLK, CSn and MOSI pass through 2-FF synchronisers. Edges are detected on the synchronised SCLK. clk must be ≥4× SCLK.
- Edge mapping: leading edge = rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, trailing if CPHA=1; the other edge is the shift edge.
- Engine states:
  - IDLE -> SHIFT on synchronised CSn fall with EN=1.
    - Load the shift-out register from the TX head and pop.
    - If TX is empty, load 0 and set underflow.
    - MSB (bit LEN) is driven on o_MISO immediately. With CPHA=1 it is also re-driven on the first leading edge.
  - SHIFT:
    - Each sample edge shifts MOSI into rx_sr and increments bitcnt.
    - Each shift edge presents the next bit.
  - End of word, at bitcnt==LEN+1 after the sample:
    - Push rx_sr[LEN:0] into RX and set st7. If RX is full, drop the word and set overflow.
    - Reload TX as on entry, so back-to-back words continue without CSn toggling.
  - SHIFT -> IDLE on CSn rise. A partial word is discarded, bitcnt is cleared, nothing is pushed.
  - EN=0 holds the engine in IDLE; MISO is 0.
- Simultaneous events:
  - Bus pop and engine push in the same cycle leave the level unchanged.
  - FLUSH together with push or pop: FLUSH wins.
  - A W1C clear and a set of the same flag in the same cycle: the set wins.
- Changing CTRL mode or LEN while busy is undefined by contract and must not lock the engine; the next CSn fall recovers.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: CTRL[13] LSBF is R/W, reset 0. When LSBF=1, bit 0 is shifted out first and received bits fill from MSB downward, so the RX word is the same value as sent.
- Undefined: CTRL[13] reads 0, writes are ignored, and transfers are MSB-first only.

Test Plan:
- Reset, then read CTRL and STATUS -> CTRL=0x087 (LEN 7, EN 1); STATUS[1]=1, [3]=1, all other bits 0; o_int=0.
- Mode 0, LEN 7: write 0xA5 to DATA; master sends 0x3C with CSn low for 8 clocks -> MISO carries 0xA5 MSB-first; DATA read returns 0x3C; st7=1; RX level 0.
- All four CPOL/CPHA modes, LEN 15 and LEN 31 (DATA_W=32): back-to-back words under one CSn -> every word round-trips exactly.
- RX overflow: disable reads, master sends DEPTH+1 words -> RX full, st5=1, o_int=1 with IE3=1; write 0x20 to STATUS -> st5 clears.
- Underflow and abort: CSn low with TX empty -> MISO all 0, st6=1; CSn raised after 3 bits -> no RX push, next full word is received correctly.
- With SPI_LSB_FIRST_EN, LSBF=1: TX 0x01 -> MISO first bit is 1; master sends LSB-first 0x80 -> DATA read returns 0x80.
